// File: rtl/max_frame_reduce.sv
// Frame-level reducer behind the pipelined max tree: realigns sideband with tree output,
// folds beat maxima per frame and queues (max, beats) results in a 2-entry output FIFO.
module max_frame_reduce #(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned BEAT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic              src_last,
    input  logic [SIZE-1:0]   max_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SIZE-1:0]   res_data,
    output logic [BEAT_W-1:0] res_beats,
    output logic              overflow
);

    typedef enum logic {StIdle, StAcc} state_e;

    logic av;
    logic al;

    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign av = src_valid;
            assign al = src_last;
        end else begin : g_delay
            logic [PIPE_LAT-1:0] sr_valid_q;
            logic [PIPE_LAT-1:0] sr_last_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sr_valid_q <= '0;
                    sr_last_q  <= '0;
                end else begin
                    sr_valid_q[0] <= src_valid;
                    sr_last_q[0]  <= src_last;
                    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                        sr_valid_q[i] <= sr_valid_q[i-1];
                        sr_last_q[i]  <= sr_last_q[i-1];
                    end
                end
            end

            assign av = sr_valid_q[PIPE_LAT-1];
            assign al = sr_last_q[PIPE_LAT-1];
        end
    endgenerate

    // Accumulator FSM
    state_e            state_q, state_d;
    logic [SIZE-1:0]   acc_q, acc_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]   max_sel;
    logic [BEAT_W-1:0] cnt_inc;
    logic              push;
    logic [SIZE-1:0]   push_data;
    logic [BEAT_W-1:0] push_beats;

    assign max_sel = (max_in > acc_q) ? max_in : acc_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_data  = max_in;
        push_beats = BEAT_W'(1);
        if (av) begin
            unique case (state_q)
                StIdle: begin
                    if (al) begin
                        push = 1'b1;
                    end else begin
                        acc_d   = max_in;
                        cnt_d   = BEAT_W'(1);
                        state_d = StAcc;
                    end
                end
                StAcc: begin
                    if (al) begin
                        push       = 1'b1;
                        push_data  = max_sel;
                        push_beats = cnt_inc;
                        state_d    = StIdle;
                    end else begin
                        acc_d = max_sel;
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output FIFO: explicit head/tail slots so the head holds its value once drained
    logic [SIZE-1:0]   head_data_q, head_data_d;
    logic [BEAT_W-1:0] head_beats_q, head_beats_d;
    logic [SIZE-1:0]   tail_data_q, tail_data_d;
    logic [BEAT_W-1:0] tail_beats_q, tail_beats_d;
    logic [1:0]        count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop;

    assign pop = (count_q != 2'd0) & res_ready;

    always_comb begin
        head_data_d  = head_data_q;
        head_beats_d = head_beats_q;
        tail_data_d  = tail_data_q;
        tail_beats_d = tail_beats_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_data_d  = push_data;
                    head_beats_d = push_beats;
                    count_d      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d  = push_data;
                    head_beats_d = push_beats;
                end else if (push) begin
                    tail_data_d  = push_data;
                    tail_beats_d = push_beats;
                    count_d      = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_d  = tail_data_q;
                    head_beats_d = tail_beats_q;
                    if (push) begin
                        tail_data_d  = push_data;
                        tail_beats_d = push_beats;
                    end else begin
                        count_d = 2'd1;
                    end
                end else if (push) begin
                    overflow_d = 1'b1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data_q  <= '0;
            head_beats_q <= '0;
            tail_data_q  <= '0;
            tail_beats_q <= '0;
            count_q      <= 2'd0;
            overflow_q   <= 1'b0;
        end else begin
            head_data_q  <= head_data_d;
            head_beats_q <= head_beats_d;
            tail_data_q  <= tail_data_d;
            tail_beats_q <= tail_beats_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign res_valid = (count_q != 2'd0);
    assign res_data  = head_data_q;
    assign res_beats = head_beats_q;
    assign overflow  = overflow_q;

endmodule
